mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, response and data-memory signals of mem_arbiter.
// The slave side is the arbiter; the master side is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int N = 8
);
    logic         req0;
    logic         req1;
    logic         we0;
    logic         we1;
    logic [N-1:0] addr0;
    logic [N-1:0] addr1;
    logic [N-1:0] wdata0;
    logic [N-1:0] wdata1;
    logic         gnt0;
    logic         gnt1;
    logic         rvalid0;
    logic         rvalid1;
    logic [N-1:0] rdata;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_we;
    logic [N-1:0] mem_rdata;
    logic         busy;

    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        input  mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1,
        output rdata, mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        output mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1,
        input  rdata, mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for a single-port data memory.
// Fixed priority (requester 0) by default; define MEM_ARB_RR_EN for round-robin.
module mem_arbiter #(
    parameter int N = 8,
    parameter int M = 8
) (
    input logic            clk,
    input logic            rst,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    if (M > N) begin : g_depth_check
        $error("mem_arbiter: M must not exceed N");
    end

    state_t       state;
    state_t       state_nx;
    logic         any_req;
    logic         win;
    logic         take;
    logic         lat_we;
    logic         lat_own;
    logic [N-1:0] lat_addr;
    logic [N-1:0] lat_wdata;
    logic [N-1:0] rdata_q;

    assign any_req = bus.req0 | bus.req1;
    assign take    = (state == IDLE) && any_req;

`ifdef MEM_ARB_RR_EN
    logic last_owner;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        win = bus.req1;
        if (bus.req0 && bus.req1) win = ~last_owner;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_owner <= 1'b1;
        else if (take) last_owner <= win;
    end
`else
    assign win = ~bus.req0 & bus.req1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        bus.gnt0    = 1'b0;
        bus.gnt1    = 1'b0;
        bus.rvalid0 = 1'b0;
        bus.rvalid1 = 1'b0;
        bus.mem_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) state_nx = ACCESS;
            end
            ACCESS: begin
                state_nx   = RESP;
                bus.mem_we = lat_we;
                bus.gnt0   = ~lat_own;
                bus.gnt1   = lat_own;
            end
            RESP: begin
                state_nx    = IDLE;
                bus.rvalid0 = ~lat_we & ~lat_own;
                bus.rvalid1 = ~lat_we & lat_own;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The latches only move on the IDLE->ACCESS edge, so the memory bus
    // keeps its last address/data outside ACCESS without extra registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_own   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (take) begin
            lat_own   <= win;
            lat_we    <= win ? bus.we1    : bus.we0;
            lat_addr  <= win ? bus.addr1  : bus.addr0;
            lat_wdata <= win ? bus.wdata1 : bus.wdata0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (state == ACCESS && !lat_we)
            rdata_q <= bus.mem_rdata;
    end

    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and scoreboarded checks of mem_arbiter.
// Builds with or without MEM_ARB_RR_EN; expectations follow the same macro.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int N = 8;
    localparam int M = 8;
    localparam logic [N-1:0] SWITCHES = 8'h3C;
    localparam logic [N-1:0] IO_ADDR  = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.N(N)) bus ();

    mem_arbiter #(.N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory model; the top word is a switch input port.
    logic [N-1:0] mem [2**M];
    assign bus.mem_rdata = (bus.mem_addr == IO_ADDR) ? SWITCHES
                                                     : mem[bus.mem_addr[M-1:0]];
    always @(posedge clk)
        if (bus.mem_we) mem[bus.mem_addr[M-1:0]] <= bus.mem_wdata;

    typedef struct {
        logic         own;
        logic         we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
    } gexp_t;

    typedef struct {
        logic         own;
        logic [N-1:0] data;
    } rexp_t;

    typedef struct {
        logic         r0;
        logic         w0;
        logic [N-1:0] a0;
        logic [N-1:0] d0;
        logic [N-1:0] x0;
        logic         r1;
        logic         w1;
        logic [N-1:0] a1;
        logic [N-1:0] d1;
        logic [N-1:0] x1;
    } vec_t;

    gexp_t gq[$];
    rexp_t rq[$];
    vec_t  tbl[10];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;

`ifdef MEM_ARB_RR_EN
    logic exp_last = 1'b1;
`endif

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input logic [N-1:0] act,
                        input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic arb(input logic r0, input logic r1);
`ifdef MEM_ARB_RR_EN
        if (r0 && r1) return ~exp_last;
`else
        if (r0 && r1) return 1'b0;
`endif
        return r1;
    endfunction

    task automatic note_owner(input logic own);
`ifdef MEM_ARB_RR_EN
        exp_last = own;
`else
        if (own === 1'bx) $display("note_owner: unknown owner");
`endif
    endtask

    task automatic drop_reqs();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_mem_we"},  bus.mem_we,  1'b0);
        chk1({tag, "_gnt0"},    bus.gnt0,    1'b0);
        chk1({tag, "_gnt1"},    bus.gnt1,    1'b0);
        chk1({tag, "_rvalid0"}, bus.rvalid0, 1'b0);
        chk1({tag, "_rvalid1"}, bus.rvalid1, 1'b0);
        chk1({tag, "_busy"},    bus.busy,    1'b0);
        chkn({tag, "_rdata"},   bus.rdata,   '0);
        chkn({tag, "_addr"},    bus.mem_addr,  '0);
        chkn({tag, "_wdata"},   bus.mem_wdata, '0);
    endtask

    // One clock; at the falling edge the scoreboard checks grants and reads.
    task automatic tick();
        gexp_t g;
        rexp_t r;
        @(negedge clk);
        cyc++;
        chk1("gnt_onehot", bus.gnt0 & bus.gnt1, 1'b0);
        chk1("rvalid_onehot", bus.rvalid0 & bus.rvalid1, 1'b0);
        if (bus.gnt0 || bus.gnt1) begin
            if (gq.size() == 0) begin
                chk1("gnt_unexpected", 1'b1, 1'b0);
            end else begin
                g = gq.pop_front();
                chk1("gnt_owner", bus.gnt1, g.own);
                chk1("mem_we", bus.mem_we, g.we);
                chkn("mem_addr", bus.mem_addr, g.addr);
                if (g.we) chkn("mem_wdata", bus.mem_wdata, g.wdata);
                chk1("busy_access", bus.busy, 1'b1);
            end
        end else begin
            chk1("mem_we_outside", bus.mem_we, 1'b0);
        end
        if (bus.rvalid0 || bus.rvalid1) begin
            if (rq.size() == 0) begin
                chk1("rvalid_unexpected", 1'b1, 1'b0);
            end else begin
                r = rq.pop_front();
                chk1("rvalid_owner", bus.rvalid1, r.own);
                chkn("rdata", bus.rdata, r.data);
            end
        end
    endtask

    task automatic push_access(input vec_t v, output logic own, output logic we);
        own = arb(v.r0, v.r1);
        note_owner(own);
        we  = own ? v.w1 : v.w0;
        gq.push_back('{own, we, own ? v.a1 : v.a0, own ? v.d1 : v.d0});
        if (!we) rq.push_back('{own, own ? v.x1 : v.x0});
    endtask

    // Called at a falling edge with the arbiter in IDLE.
    task automatic run_vec(input vec_t v);
        logic own;
        logic we;
        bus.req0   = v.r0;
        bus.we0    = v.w0;
        bus.addr0  = v.a0;
        bus.wdata0 = v.d0;
        bus.req1   = v.r1;
        bus.we1    = v.w1;
        bus.addr1  = v.a1;
        bus.wdata1 = v.d1;
        push_access(v, own, we);
        tick();
        chk1("gnt_latency", own ? bus.gnt1 : bus.gnt0, 1'b1);
        drop_reqs();
        tick();
        chk1("rvalid_latency", own ? bus.rvalid1 : bus.rvalid0, ~we);
        chk1("busy_resp", bus.busy, 1'b1);
        tick();
        chk1("busy_idle", bus.busy, 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        drop_reqs();
        tick();
        rst = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_last = 1'b1;
`endif
    endtask

    initial begin
        int   seen;
        int   last_c;
        vec_t v;
        logic own;
        logic we;

        //        r0 w0  a0     d0     x0     r1 w1  a1     d1     x1
        tbl[0] = '{1, 1, 8'h10, 8'hA5, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 8'hA5};
        tbl[2] = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h20, 8'h5A, 8'h00};
        tbl[3] = '{1, 0, 8'h20, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{1, 0, 8'hFF, 8'h00, 8'h3C, 0, 0, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{1, 1, 8'h30, 8'h11, 8'h00, 1, 1, 8'h31, 8'h22, 8'h00};
        tbl[6] = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h40, 8'h77, 8'h00};
        tbl[7] = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 8'h77};
        tbl[8] = '{1, 0, 8'h10, 8'h00, 8'hA5, 0, 0, 8'h00, 8'h00, 8'h00};
        tbl[9] = '{1, 0, 8'h10, 8'h00, 8'hA5, 1, 0, 8'h20, 8'h00, 8'h5A};

        rst = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Both requesters held high from reset: grants every 3 cycles.
        pulse_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        v = '{1, 0, 8'h10, 8'h00, 8'hA5, 1, 0, 8'h20, 8'h00, 8'h5A};
        for (int i = 0; i < 4; i++) push_access(v, own, we);
        seen   = 0;
        last_c = 0;
        for (int i = 0; i < 20 && seen < 4; i++) begin
            tick();
            if (bus.gnt0 || bus.gnt1) begin
                if (seen == 0) chki("first_gnt_cycle", i, 0);
                else           chki("gnt_spacing", cyc - last_c, 3);
                last_c = cyc;
                seen++;
                if (seen == 4) drop_reqs();
            end
        end
        chki("contention_gnt_count", seen, 4);
        tick();
        tick();
        chk1("contention_idle", bus.busy, 1'b0);

        // Reset during the ACCESS cycle of a write must not commit it.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 8'hEE;
        gq.push_back('{1'b0, 1'b1, 8'h20, 8'hEE});
        tick();
        chk1("abort_gnt0", bus.gnt0, 1'b1);
        chk1("abort_we_before", bus.mem_we, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        drop_reqs();
        tick();
        rst = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_last = 1'b1;
`endif
        tick();
        chk1("abort_no_rvalid", bus.rvalid0 | bus.rvalid1, 1'b0);
        run_vec('{1, 0, 8'h20, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00});
        run_vec('{0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'hFD, 8'h9C, 8'h00});
        chkn("addr_passthrough_fd", mem[8'hFD], 8'h9C);

        chki("grants_left", gq.size(), 0);
        chki("reads_left", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
